// File: rtl/multicycle_comparator.sv
// Iterative magnitude comparator: one CHUNK-bit slice per cycle, MSB slice first.
// Define MULTICYCLE_COMPARATOR_EARLY_EXIT_EN to finish on the first differing slice.
module multicycle_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             lt_flag;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sign_q;

  logic             accept;
  logic             flip;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             differ;
  logic             chunk_lt;
  logic             last;
  logic             stop;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [CHUNK-1:0] msb_bias(input logic [CHUNK-1:0] c,
                                                input logic flip_en);
    return c ^ (CHUNK'(flip_en) << (CHUNK - 1));
  endfunction

  assign accept = i_valid && (state == IDLE);

  always_comb begin
    flip     = sign_q && (idx == '0);
    ca       = msb_bias(a_sh[WIDTH-1 -: CHUNK], flip);
    cb       = msb_bias(b_sh[WIDTH-1 -: CHUNK], flip);
    differ   = (ca != cb);
    chunk_lt = (ca < cb);
    last     = (idx == LAST_IDX);
`ifdef MULTICYCLE_COMPARATOR_EARLY_EXIT_EN
    stop     = last || (differ && !decided);
`else
    stop     = last;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = BUSY;
      BUSY:    if (stop)    state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Control: state, slice index and the sticky decision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      decided <= 1'b0;
      lt_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx     <= '0;
        decided <= 1'b0;
        lt_flag <= 1'b0;
      end else if (state == BUSY) begin
        if (!last) idx <= idx + 1'b1;
        if (!decided && differ) begin
          decided <= 1'b1;
          lt_flag <= chunk_lt;
        end
      end
    end
  end

  // Operand shifters: the slice under test is always the top CHUNK bits.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_sh   <= i_a;
      b_sh   <= i_b;
      sign_q <= i_signed;
    end else if (state == BUSY) begin
      a_sh <= a_sh << CHUNK;
      b_sh <= b_sh << CHUNK;
    end
  end

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_lt    = o_valid && decided && lt_flag;
  assign o_gt    = o_valid && decided && !lt_flag;
  assign o_eq    = o_valid && !decided;

endmodule

// File: tb/tb_multicycle_comparator.sv
// Randomized bench for multicycle_comparator against a plain-arithmetic model
// of result and latency (latency model follows MULTICYCLE_COMPARATOR_EARLY_EXIT_EN).
module tb_multicycle_comparator;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [WIDTH-1:0]  i_a = '0;
  logic [WIDTH-1:0]  i_b = '0;
  logic              i_signed = 1'b0;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic              o_lt, o_eq, o_gt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_signed(i_signed),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_lt    (o_lt),
    .o_eq    (o_eq),
    .o_gt    (o_gt)
  );

  // {lt, eq, gt}
  function automatic logic [2:0] model_cmp(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    if (a == b) return 3'b010;
    if (s) return ($signed(a) < $signed(b)) ? 3'b100 : 3'b001;
    return (a < b) ? 3'b100 : 3'b001;
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULTICYCLE_COMPARATOR_EARLY_EXIT_EN
    logic [31:0] d;
    d = a ^ b;
    for (int k = 0; k < NCHUNK; k++)
      if (((d >> (WIDTH - CHUNK * (k + 1))) & 32'hFF) != 0) return k + 1;
    return NCHUNK;
`else
    return NCHUNK + 0 * int'(a[0] ^ b[0]);
`endif
  endfunction

  // Present a request from a post-edge point, scramble inputs after acceptance,
  // and wait (bounded) for o_valid; leaves the DUT in DONE unless i_ready is high.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat, output logic [2:0] res, output bit to);
    i_a = a; i_b = b; i_signed = s; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_signed = ~s;
    lat = 0; to = 1'b1;
    for (int i = 0; i < 20 && to; i++) begin
      @(posedge clk); #1;
      lat++;
      if (o_valid) to = 1'b0;
    end
    res = {o_lt, o_eq, o_gt};
  endtask

  task automatic release_result;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    int lat; logic [2:0] res; bit to;
    #2;
    total++;
    if ({o_ready, o_valid, o_lt, o_eq, o_gt} !== 5'b10000) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", {o_ready, o_valid, o_lt, o_eq, o_gt}, 5'b10000);
    end
    i_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_ready, o_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_ignores_valid got=%b want=10", {o_ready, o_valid});
    end
    i_valid = 1'b0;
    rst_n = 1'b1;
    issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat, res, to);
    total++;
    if (to || res !== 3'b100 || lat != NCHUNK) begin
      bad++; $display("FAIL first_after_reset to=%0d res=%b lat=%0d want res=100 lat=%0d", to, res, lat, NCHUNK);
    end
    release_result();
  endtask

  task automatic test_directed;
    logic [31:0] av [6] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] bv [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000};
    logic        sv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  ev [6] = '{3'b100, 3'b001, 3'b100, 3'b010, 3'b010, 3'b001};
    int lat; logic [2:0] res; bit to;
    for (int i = 0; i < 6; i++) begin
      issue(av[i], bv[i], sv[i], lat, res, to);
      total++;
      if (to || res !== ev[i] || lat != model_lat(av[i], bv[i])) begin
        bad++; $display("FAIL directed_%0d to=%0d res=%b lat=%0d want res=%b lat=%0d", i, to, res, lat, ev[i], model_lat(av[i], bv[i]));
      end
      release_result();
    end
`ifdef MULTICYCLE_COMPARATOR_EARLY_EXIT_EN
    issue(32'h8000_0000, 32'h0, 1'b0, lat, res, to);
    total++;
    if (lat != 1) begin bad++; $display("FAIL early_exit_lat got=%0d want=1", lat); end
`else
    issue(32'h8000_0000, 32'h0, 1'b0, lat, res, to);
    total++;
    if (lat != NCHUNK) begin bad++; $display("FAIL fixed_lat got=%0d want=%0d", lat, NCHUNK); end
`endif
    release_result();
  endtask

  task automatic test_hold;
    int lat; logic [2:0] res; bit to;
    issue(32'h0000_0005, 32'h0000_0009, 1'b0, lat, res, to);
    total++;
    if (to || res !== 3'b100) begin bad++; $display("FAIL hold_result to=%0d res=%b want=100", to, res); end
    for (int i = 0; i < 5; i++) begin
      i_valid = ~i_valid; i_a = $urandom; i_b = $urandom;
      @(posedge clk); #1;
      total++;
      if ({o_lt, o_eq, o_gt} !== res || o_valid !== 1'b1 || o_ready !== 1'b0) begin
        bad++; $display("FAIL hold_cycle_%0d res=%b valid=%b ready=%b want res=%b valid=1 ready=0", i, {o_lt, o_eq, o_gt}, o_valid, o_ready, res);
      end
    end
    i_valid = 1'b0;
    release_result();
    total++;
    if ({o_ready, o_valid} !== 2'b10) begin bad++; $display("FAIL hold_release got=%b want=10", {o_ready, o_valid}); end
  endtask

  task automatic test_abort;
    int lat; logic [2:0] res; bit to; bit seen;
    i_a = 32'hCAFE_BABE; i_b = 32'hCAFE_BABE; i_signed = 1'b0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_ready, o_valid, o_lt, o_eq, o_gt} !== 5'b10000) begin
      bad++; $display("FAIL abort_async got=%b want=10000", {o_ready, o_valid, o_lt, o_eq, o_gt});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (o_valid || !o_ready) seen = 1'b1; end
    total++;
    if (seen) begin bad++; $display("FAIL abort_no_result got valid/busy after abort want none"); end
    issue(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, lat, res, to);
    total++;
    if (to || res !== 3'b100 || lat != model_lat(32'hFFFF_FFFE, 32'h3)) begin
      bad++; $display("FAIL after_abort to=%0d res=%b lat=%0d want res=100", to, res, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back;
    int lat; logic [2:0] res; bit to; bit done;
    issue(32'h0101_0101, 32'h0101_0100, 1'b0, lat, res, to);
    total++;
    if (to || res !== 3'b001) begin bad++; $display("FAIL b2b_first to=%0d res=%b want=001", to, res); end
    i_a = 32'h0000_0010; i_b = 32'h7000_0010; i_signed = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({o_ready, o_valid} !== 2'b10) begin bad++; $display("FAIL b2b_handoff got=%b want=10", {o_ready, o_valid}); end
    @(posedge clk); #1;
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept ready=%b want=0", o_ready); end
    i_valid = 1'b0;
    lat = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1; lat++;
      if (o_valid) done = 1'b1;
    end
    total++;
    if (!done || {o_lt, o_eq, o_gt} !== 3'b100 || lat != model_lat(32'h10, 32'h7000_0010)) begin
      bad++; $display("FAIL b2b_second done=%0d res=%b lat=%0d want res=100 lat=%0d", done, {o_lt, o_eq, o_gt}, lat, model_lat(32'h10, 32'h7000_0010));
    end
    @(posedge clk); #1;
    i_ready = 1'b0;
    total++;
    if ({o_ready, o_valid} !== 2'b10) begin bad++; $display("FAIL b2b_return got=%b want=10", {o_ready, o_valid}); end
  endtask

  task automatic test_random;
    int lat; logic [2:0] res; bit to;
    logic [31:0] a, b, r;
    logic s;
    for (int n = 0; n < 40; n++) begin
      a = $urandom; r = $urandom; b = a;
      for (int k = 0; k < NCHUNK; k++)
        if ($urandom_range(0, 2) == 0) b[k*CHUNK +: CHUNK] = r[k*CHUNK +: CHUNK];
      if (n % 7 == 3) b[31] = ~a[31];
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, lat, res, to);
      total++;
      if (to || res !== model_cmp(a, b, s) || lat != model_lat(a, b)) begin
        bad++; $display("FAIL random_%0d a=%h b=%h s=%0d res=%b lat=%0d want res=%b lat=%0d", n, a, b, s, res, lat, model_cmp(a, b, s), model_lat(a, b));
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
